// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake bundle between a binary source and the BCD converter.
interface bin2bcd_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [31:0]      bcd;

  modport master (output start, output din, input busy, input done, input ovf, input bcd);
  modport slave  (input start, input din, output busy, output done, output ovf, output bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one binary bit per clock into a 10-digit scratch,
// publishing an 8-digit packed BCD word (or all-F on overflow) with a one-cycle done pulse.
module bin2bcd_seq #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  bin2bcd_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] bin_q, bin_next;
  logic [39:0]      scr_q, scr_next;
  logic [5:0]       cnt_q, cnt_next;
  logic             ovf_pend_q, ovf_pend_next;
  logic             busy_q, busy_next;
  logic             done_q, done_next;
  logic             ovf_q, ovf_next;
  logic [31:0]      bcd_q, bcd_next;
  logic [31:0]      din_ext;
  logic             din_big;
  logic [39:0]      adj;

  function automatic logic [39:0] add3_digits(input logic [39:0] s);
    logic [39:0] r;
    r = s;
    for (int i = 0; i < 10; i++) begin
      if (s[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [31:0] sat_bcd(input logic pend, input logic [39:0] s);
    return pend ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  assign din_ext = 32'(bus.din);

  // Below 27 bits din cannot reach 100_000_000, so the compare is elided.
  generate
    if (WIDTH >= 27) begin : g_ovf
      assign din_big = (din_ext > 32'd99_999_999);
    end else begin : g_no_ovf
      assign din_big = 1'b0;
    end
  endgenerate

  assign adj = add3_digits(scr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bin_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
    end else begin
      state      <= state_next;
      bin_q      <= bin_next;
      scr_q      <= scr_next;
      cnt_q      <= cnt_next;
      ovf_pend_q <= ovf_pend_next;
      busy_q     <= busy_next;
      done_q     <= done_next;
      ovf_q      <= ovf_next;
      bcd_q      <= bcd_next;
    end
  end

  always_comb begin
    state_next    = state;
    bin_next      = bin_q;
    scr_next      = scr_q;
    cnt_next      = cnt_q;
    ovf_pend_next = ovf_pend_q;
    busy_next     = busy_q;
    done_next     = 1'b0;
    ovf_next      = ovf_q;
    bcd_next      = bcd_q;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          bin_next      = bus.din;
          scr_next      = '0;
          cnt_next      = '0;
          ovf_pend_next = din_big;
          busy_next     = 1'b1;
          state_next    = SHIFT;
        end
      end
      SHIFT: begin
        scr_next = {adj[38:0], bin_q[WIDTH-1]};
        bin_next = {bin_q[WIDTH-2:0], 1'b0};
        cnt_next = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH - 1)) begin
          bcd_next   = sat_bcd(ovf_pend_q, scr_next);
          ovf_next   = ovf_pend_q;
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed handshake cases plus random values against a decimal model.
module tb_bin2bcd_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bin2bcd_if #(.WIDTH(WIDTH)) bus ();
  bin2bcd_seq #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] model_bcd(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] x;
    if (v > 32'd99_999_999) return 32'hFFFF_FFFF;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and wait for done; returns cycles from acceptance to done.
  task automatic run_conv(input logic [31:0] v, input string tag, input bit full);
    int          k;
    logic        busy_ok;
    logic        stable;
    logic [31:0] bcd0;
    @(negedge clk);
    bcd0      = bus.bcd;
    bus.start = 1'b1;
    bus.din   = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = $urandom;
    k = 1; busy_ok = 1'b1; stable = 1'b1;
    while (!bus.done && k < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.bcd !== bcd0) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(WIDTH + 1));
    chk({tag, "_bcd"}, bus.bcd, model_bcd(v));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(v > 32'd99_999_999));
    if (full) begin
      chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
      chk({tag, "_bcd_stable"}, 32'(stable), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk({tag, "_done_width"}, 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    int          k;
    int          dones;
    logic [31:0] v;
    logic [31:0] first_bcd;

    bus.start = 1'b0;
    bus.din   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_bcd", bus.bcd, 32'h0);

    run_conv(32'd0, "zero", 1'b1);
    chk("zero_lit", bus.bcd, 32'h0000_0000);
    run_conv(32'd12_345_678, "mid", 1'b1);
    chk("mid_lit", bus.bcd, 32'h1234_5678);
    run_conv(32'd99_999_999, "max", 1'b1);
    chk("max_lit", bus.bcd, 32'h9999_9999);
    run_conv(32'd100_000_000, "ovf_edge", 1'b1);
    chk("ovf_edge_flag", 32'(bus.ovf), 32'd1);
    run_conv(32'hFFFF_FFFF, "ovf_all", 1'b1);
    run_conv(32'd42, "lat42", 1'b1);
    chk("lat42_lit", bus.bcd, 32'h0000_0042);

    // Start pulse with a new din mid-conversion must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.din = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.din = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0;
    first_bcd = '0;
    for (int i = 0; i < 80; i++) begin
      if (bus.done) begin
        dones++;
        first_bcd = bus.bcd;
      end
      @(negedge clk);
    end
    chk("ignore_dones", 32'(dones), 32'd1);
    chk("ignore_bcd", first_bcd, 32'h0000_0007);

    // Back-to-back: start held, new din presented during the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.din = 32'd5;
    k = 0;
    @(negedge clk);
    while (!bus.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_first_bcd", bus.bcd, 32'h0000_0005);
    bus.din = 32'd6;
    k = 0;
    @(negedge clk);
    k++;
    while (!bus.done && k < 100) begin
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk("b2b_gap", 32'(k), 32'(WIDTH + 1));
    chk("b2b_second_bcd", bus.bcd, 32'h0000_0006);
    repeat (2) @(negedge clk);

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.din = 32'd12_345_678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_bcd", bus.bcd, 32'h0);
    chk("abort_ovf", 32'(bus.ovf), 32'd0);
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_conv(32'd1, "after_abort", 1'b1);
    chk("after_abort_lit", bus.bcd, 32'h0000_0001);

    for (int i = 0; i < 1000; i++) begin
      if (i % 2 == 0) v = $urandom;
      else v = $urandom_range(99_999_999, 0);
      run_conv(v, "rand", 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the 8-digit seven-segment scanner. Converts a CPU-side binary value (register, PC, counter) into the packed 8-digit BCD word the scanner displays.
- Start/busy/done handshake; the result is held stable between conversions, so the scanner can sample it on any cycle.

Parameters:
- WIDTH, 32, binary input width. Legal range is 4..32.
- Overflow detection is active only when WIDTH >= 27.

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  synchronous reset, active-high
- start  input  1  conversion request; sampled on posedge
- din  input  WIDTH  unsigned binary value; sampled only on the accepting edge
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when bcd/ovf update
- ovf  output  1  last accepted din exceeded 99_999_999; held until the next done
- bcd  output  32  packed BCD, digit7 in [31:28] through digit0 in [3:0]; held between conversions

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high (rst sampled on posedge clk).
- Reset values: busy=0, done=0, ovf=0, bcd=32'h0000_0000, state=IDLE, iteration count=0, scratch cleared.
- States: IDLE, SHIFT.
  - There is no separate DONE state; done is a registered pulse issued on the SHIFT->IDLE edge.
- IDLE:
  - On an edge with start=1: latch din into the binary shift register.
  - Clear the 40-bit BCD scratch (10 digits, so any 32-bit value fits).
  - Set count=0, busy<=1, state<=SHIFT.
  - Latch ovf_pending = (din > 99_999_999).
  - With start=0, stay in IDLE; outputs hold.
- SHIFT, each edge:
  - For every scratch digit >= 5, add 3 (4-bit, no carry between digits).
  - Then shift {scratch, binary} left 1; the binary MSB enters scratch bit 0.
  - count<=count+1.
- Completion: on the edge where count==WIDTH-1, the final iteration executes and in the same edge:
  - bcd <= ovf_pending ? 32'hFFFF_FFFF : scratch_next[31:0]
  - ovf <= ovf_pending
  - done<=1, busy<=0, state<=IDLE
- Latency: start sampled at edge N gives done high during the cycle after edge N+WIDTH. For WIDTH=32 that is 32 cycles of busy, then done.
- done is exactly 1 cycle wide. It deasserts on the next edge regardless of start.
- start while busy=1 is ignored. It is not queued, and din changes are ignored.
- start high during the done cycle (state already IDLE) is accepted. Back-to-back throughput is one conversion per WIDTH+1 cycles.
- start held continuously: a new conversion begins every WIDTH+1 cycles.
- Between completions, bcd and ovf do not change (glitch-free for the scanner).
- Reset mid-conversion:
  - Abort and return to reset values. bcd clears to 0 and no done pulse is issued.
  - Reset takes priority over start on the same edge.
- Overflow: din=99_999_999 is valid (ovf=0); din=100_000_000 and above sets ovf=1 and bcd shows FFFF_FFFF.
- Width rule: din is zero-extended internally to 32 bits for the overflow compare.

Test Plan:
- Directed values (after reset, start 1 cycle):
  - din=0 -> done 32 cycles later, bcd=32'h0000_0000, ovf=0.
  - din=12_345_678 -> bcd=32'h1234_5678, ovf=0.
  - din=99_999_999 -> bcd=32'h9999_9999, ovf=0.
  - din=100_000_000 -> bcd=32'hFFFF_FFFF, ovf=1.
  - din=32'hFFFF_FFFF -> bcd=32'hFFFF_FFFF, ovf=1.
- Latency/handshake:
  - Start at edge N with din=42 -> busy=1 cycles N+1..N+32, done=1 only in cycle N+33 window, bcd=32'h0000_0042.
  - bcd unchanged before the done cycle.
- Ignore-while-busy: start din=7, then pulse start with din=9 at cycle +10 -> single done, bcd=32'h0000_0007.
- Back-to-back: start held high with din=5 then din=6 presented in the done cycle -> second done exactly 33 cycles after the first, bcd=32'h0000_0006.
- Reset mid-op: start din=12_345_678, assert rst at cycle +15 for 1 cycle -> busy=0, done never pulses, bcd=0, ovf=0. A subsequent start with din=1 -> bcd=32'h0000_0001.
- Random: 1000 random 32-bit din values -> bcd matches the golden decimal model (or FFFF_FFFF with ovf=1 above 99_999_999).
